esm_instr_dispatcher: RTL and testbench

ESM_INSTR_DISPATCHER -- requirements
Module: esm_instr_dispatcher

---
 rtl/esm_instr_dispatcher.sv | 114 +++++++++++
 tb/tb_esm_instr_dispatcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/esm_instr_dispatcher.sv
// esm_instr_dispatcher: dependency-tracking instruction buffer that dispatches slots chosen by a mapping core.
// Define ESM_DISPATCH_ERRCNT_EN to count selections dropped for an invalid or dependent slot.
module esm_instr_dispatcher #(
    parameter int bs = 16,
    parameter int IW = 32,
    parameter int RW = 5,
    localparam int LW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [RW-1:0] in_dst,
    input  logic [RW-1:0] in_src1,
    input  logic [RW-1:0] in_src2,
    output logic [0:bs-1] independent_instr,
    input  logic [LW-1:0] next_buffer_index,
    input  logic          valid_count,
    output logic          proceed,
    output logic [LW-1:0] buffer_index,
    output logic [LW-1:0] buffer_index_synchronizer_1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [7:0]    err_count
);
    logic [bs-1:0] valid_q, valid_d, new_dep;
    logic [bs-1:0] dep_q [bs];
    logic [bs-1:0] dep_d [bs];
    logic [IW-1:0] instr_q [bs];
    logic [RW-1:0] dst_q [bs];
    logic [0:bs-1] indep_q;
    logic          out_valid_q;
    logic [IW-1:0] out_instr_q;
    logic [LW-1:0] bi_q, bi1_q, free_idx;
    logic          sel_ok, accept, insert;

    assign in_ready = ~&valid_q;
    assign proceed = ~out_valid_q | out_ready;
    assign sel_ok = valid_q[next_buffer_index] & ~|dep_q[next_buffer_index];
    assign accept = valid_count & proceed & sel_ok;
    assign insert = in_valid & in_ready;

    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) free_idx = valid_q[i] ? free_idx : LW'(i);
    end

    // The slot being dispatched this edge never becomes a producer of the new entry.
    always_comb begin
        valid_d = valid_q;
        dep_d = dep_q;
        new_dep = '0;
        for (int i = 0; i < bs; i++) begin
            if (accept) dep_d[i][next_buffer_index] = 1'b0;
            new_dep[i] = valid_q[i] & ~(accept & (next_buffer_index == LW'(i)))
                       & ((dst_q[i] == in_src1) | (dst_q[i] == in_src2));
        end
        if (accept) valid_d[next_buffer_index] = 1'b0;
        if (insert) begin
            valid_d[free_idx] = 1'b1;
            dep_d[free_idx] = new_dep;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dep_q <= '{default: '0};
            indep_q <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            bi_q <= '0;
            bi1_q <= '0;
        end else begin
            valid_q <= valid_d;
            dep_q <= dep_d;
            for (int i = 0; i < bs; i++) indep_q[i] <= valid_q[i] & ~|dep_q[i];
            bi1_q <= bi_q;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= instr_q[next_buffer_index];
                bi_q <= next_buffer_index;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (insert) begin
            instr_q[free_idx] <= in_instr;
            dst_q[free_idx] <= in_dst;
        end
    end

`ifdef ESM_DISPATCH_ERRCNT_EN
    logic [7:0] err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= '0;
        else if (valid_count & proceed & ~sel_ok & ~&err_q) err_q <= err_q + 8'd1;
    end
    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

    assign independent_instr = indep_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign buffer_index = bi_q;
    assign buffer_index_synchronizer_1 = bi1_q;
endmodule

// File: tb/tb_esm_instr_dispatcher.sv
// tb_esm_instr_dispatcher: directed stimulus against a slot-level reference model, checked every negedge.
module tb_esm_instr_dispatcher;
    localparam int BS = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 0, in_ready, valid_count = 0, proceed, out_valid, out_ready = 1;
    logic [31:0] in_instr = '0, out_instr;
    logic [4:0] in_dst = '0, in_src1 = '0, in_src2 = '0;
    logic [0:BS-1] independent_instr;
    logic [3:0] next_buffer_index = '0, buffer_index, buffer_index_synchronizer_1;
    logic [7:0] err_count;
    int checks = 0, errors = 0;

    esm_instr_dispatcher dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2), .independent_instr(independent_instr),
        .next_buffer_index(next_buffer_index), .valid_count(valid_count), .proceed(proceed),
        .buffer_index(buffer_index), .buffer_index_synchronizer_1(buffer_index_synchronizer_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: one record per slot, producers kept as a set of slot numbers.
    bit          m_valid [BS];
    bit [31:0]   m_instr [BS];
    bit [4:0]    m_dst [BS];
    bit [BS-1:0] m_dep [BS];
    bit [0:BS-1] m_ind;
    bit          m_ov;
    bit [31:0]   m_oi;
    bit [3:0]    m_bi, m_bs1;
    int          m_err;

    function automatic void m_clear();
        for (int i = 0; i < BS; i++) begin
            m_valid[i] = 0;
            m_dep[i] = '0;
        end
        m_ind = '0; m_ov = 0; m_oi = '0; m_bi = '0; m_bs1 = '0; m_err = 0;
    endfunction

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_clear();
            else begin
                int fi, nb;
                bit prc, free_ok, ok;
                bit [BS-1:0] nd;
                nb = int'(next_buffer_index);
                m_bs1 = m_bi;
                for (int i = 0; i < BS; i++) m_ind[i] = m_valid[i] && m_dep[i] == 0;
                prc = !m_ov || out_ready;
                free_ok = m_valid[nb] && m_dep[nb] == 0;
                ok = valid_count && prc && free_ok;
                fi = -1;
                for (int i = 0; i < BS; i++) if (in_valid && fi < 0 && !m_valid[i]) fi = i;
                nd = '0;
                for (int j = 0; j < BS; j++)
                    if (m_valid[j] && !(ok && j == nb) && (m_dst[j] == in_src1 || m_dst[j] == in_src2)) nd[j] = 1;
                if (ok) begin
                    m_oi = m_instr[nb]; m_ov = 1; m_valid[nb] = 0; m_bi = next_buffer_index;
                    for (int i = 0; i < BS; i++) m_dep[i][nb] = 0;
                end else if (out_ready) m_ov = 0;
`ifdef ESM_DISPATCH_ERRCNT_EN
                if (valid_count && prc && !free_ok && m_err < 255) m_err++;
`endif
                if (fi >= 0) begin
                    m_valid[fi] = 1; m_instr[fi] = in_instr; m_dst[fi] = in_dst; m_dep[fi] = nd;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        begin
            bit any_free;
            any_free = 0;
            for (int i = 0; i < BS; i++) if (!m_valid[i]) any_free = 1;
            chk("in_ready", 64'(in_ready), 64'(any_free));
            chk("proceed", 64'(proceed), 64'(!m_ov || out_ready));
            chk("independent_instr", 64'(independent_instr), 64'(m_ind));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_instr", 64'(out_instr), 64'(m_oi));
            chk("buffer_index", 64'(buffer_index), 64'(m_bi));
            chk("sync1", 64'(buffer_index_synchronizer_1), 64'(m_bs1));
            chk("err_count", 64'(err_count), 64'(m_err));
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [4:0] d, s1, s2,
                       input logic vc, input logic [3:0] nb, input logic ordy);
        in_valid = iv; in_instr = ins; in_dst = d; in_src1 = s1; in_src2 = s2;
        valid_count = vc; next_buffer_index = nb; out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic ordy);
        cyc(0, '0, '0, '0, '0, 0, '0, ordy);
    endtask

    initial begin
        logic [7:0] exp_err;
        idle(1);
        idle(1);
        chk("lit reset in_ready", 64'(in_ready), 64'd1);
        chk("lit reset out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        cyc(1, 32'hAAAA_0000, 5'd3, 5'd31, 5'd31, 0, 0, 1);
        cyc(1, 32'hBBBB_0001, 5'd10, 5'd3, 5'd31, 0, 0, 1);
        cyc(1, 32'hCCCC_0002, 5'd11, 5'd7, 5'd31, 0, 0, 1);
        idle(1);
        chk("lit indep after ABC", 64'(independent_instr), 64'(16'b1010_0000_0000_0000));
        cyc(0, '0, '0, '0, '0, 1, 4'd1, 1);
        exp_err = 8'd0;
`ifdef ESM_DISPATCH_ERRCNT_EN
        exp_err = 8'd1;
`endif
        chk("lit dropped dependent err", 64'(err_count), 64'(exp_err));
        chk("lit dropped out_valid", 64'(out_valid), 64'd0);
        cyc(0, '0, '0, '0, '0, 1, 4'd0, 1);
        chk("lit dispatch A instr", 64'(out_instr), 64'h0000_0000_AAAA_0000);
        chk("lit dispatch A bi", 64'(buffer_index), 64'd0);
        cyc(0, '0, '0, '0, '0, 1, 4'd2, 0);
        chk("lit stalled proceed", 64'(proceed), 64'd0);
        chk("lit stalled instr", 64'(out_instr), 64'h0000_0000_AAAA_0000);
        chk("lit indep B freed", 64'(independent_instr), 64'(16'b0110_0000_0000_0000));
        cyc(0, '0, '0, '0, '0, 1, 4'd1, 1);
        chk("lit dispatch B", 64'(out_instr), 64'h0000_0000_BBBB_0001);
        cyc(0, '0, '0, '0, '0, 1, 4'd2, 1);
        chk("lit dispatch C", 64'(out_instr), 64'h0000_0000_CCCC_0002);
        chk("lit sync1 after B", 64'(buffer_index_synchronizer_1), 64'd1);
        idle(1);
        chk("lit drained", 64'(out_valid), 64'd0);
        for (int i = 0; i < BS; i++)
            cyc(1, 32'h1000_0000 + 32'(i), 5'(i + 8), (i % 3 == 0) ? 5'(i + 7) : 5'd30, 5'd31, 0, 0, 1);
        chk("lit full in_ready", 64'(in_ready), 64'd0);
        cyc(1, 32'hDEAD_0000, 5'd4, 5'd5, 5'd6, 1, 4'd8, 1);
        chk("lit full accept 8", 64'(out_instr), 64'h0000_0000_1000_0008);
        chk("lit in_ready after free", 64'(in_ready), 64'd1);
        cyc(1, 32'hBEEF_0000, 5'd25, 5'd13, 5'd31, 1, 4'd5, 1);
        chk("lit accept 5", 64'(out_instr), 64'h0000_0000_1000_0005);
        cyc(0, '0, '0, '0, '0, 1, 4'd3, 1);
        chk("lit slot5 empty", 64'(independent_instr[5]), 64'd0);
        chk("lit slot8 refilled indep", 64'(independent_instr[8]), 64'd1);
        for (int i = 0; i < 260; i++) cyc(0, '0, '0, '0, '0, 1, 4'd5, 1);
        exp_err = 8'd0;
`ifdef ESM_DISPATCH_ERRCNT_EN
        exp_err = 8'd255;
`endif
        chk("lit err saturate", 64'(err_count), 64'(exp_err));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1, 32'h2000_0000 + 32'(i), 5'(i + 8), 5'd30, 5'd31, 0, 0, 0);
        cyc(1, 32'h2000_0008, 5'd20, 5'd30, 5'd31, 1, 4'd0, 0);
        chk("lit pre-reset out_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("lit mid reset in_ready", 64'(in_ready), 64'd1);
        chk("lit mid reset out_valid", 64'(out_valid), 64'd0);
        chk("lit mid reset instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc(0, '0, '0, '0, '0, 1, 4'd1, 1);
        chk("lit no dispatch after reset", 64'(out_valid), 64'd0);
        cyc(1, 32'h3000_0000, 5'd9, 5'd30, 5'd31, 0, 0, 1);
        cyc(0, '0, '0, '0, '0, 1, 4'd0, 1);
        chk("lit post-reset dispatch", 64'(out_instr), 64'h0000_0000_3000_0000);
        idle(1);
        idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
